input_lane_replicator: RTL
==========================

INPUT_LANE_REPLICATOR -- requirements
Module: input_lane_replicator

Interface
REQ-001 Parameter DATA_W, default 32: width of the buffer word and of every output beat.
REQ-002 Parameter LANE_W, default 2: width of the smallest precision slice (lane).
REQ-003 Parameter MAX_MODE, default 2: highest legal mode; mode m gives replication factor R=2^m and 2^m beats per word.
REQ-004 DATA_W SHALL be divisible by LANE_W*2^MAX_MODE; violation is an elaboration error.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 weight_bitwidth  input  2  mode select, sampled only on word acceptance.
REQ-008 in_valid  input  1  buffer word valid.
REQ-009 in_ready  output  1  block can accept a word this cycle.
REQ-010 buffer  input  DATA_W  raw buffer word.
REQ-011 out_valid  output  1  sorted_data holds a valid beat.
REQ-012 out_ready  input  1  downstream accepts the current beat.
REQ-013 sorted_data  output  DATA_W  replicated beat.
REQ-014 out_last  output  1  current beat is the final beat of its word.
REQ-015 beat_idx  output  MAX_MODE (min 1)  index of the current beat within its word.
REQ-016 mode_err  output  1  sticky flag, illegal mode seen.

Function
REQ-017 Word accepted on an edge where in_valid && in_ready; buffer and weight_bitwidth captured into word_q and mode_q, beat counter cleared to 0.
REQ-018 weight_bitwidth > MAX_MODE at acceptance: word processed as mode 0, mode_err set to 1 and held until reset.
REQ-019 States: IDLE (no word held) and BUSY (word held); IDLE->BUSY on accept; BUSY->IDLE on last-beat handshake with no new accept; BUSY->BUSY on last-beat handshake with a simultaneous accept.
REQ-020 out_valid = 1 exactly in BUSY; first beat visible the cycle after acceptance (latency 1 cycle).
REQ-021 in_ready = IDLE || (out_valid && out_ready && out_last); back-to-back words stream with no bubble.
REQ-022 Beat handshake (out_valid && out_ready) on a non-last beat increments beat counter by 1.
REQ-023 When out_valid && !out_ready, sorted_data, out_last and beat_idx hold stable.
REQ-024 Beat b of mode m: chunk C = word_q[(b+1)*DATA_W/R-1 : b*DATA_W/R].
REQ-025 Chunk lane i = C[(i+1)*LANE_W-1 : i*LANE_W]; output field [(i+1)*LANE_W*R-1 : i*LANE_W*R] = lane i replicated R times.
REQ-026 Mode 0: sorted_data = word_q unchanged, single beat, out_last = 1.
REQ-027 out_last = (beat counter == 2^mode_q - 1); beat_idx = beat counter.
REQ-028 sorted_data, out_last and beat_idx driven only from registered state (word_q, mode_q, beat counter), with no combinational path from inputs.
REQ-029 Mode change between words takes effect only at the next acceptance; the in-flight word completes in its captured mode.

Reset
REQ-030 reset_n low at an edge: state IDLE, word_q = 0, mode_q = 0, beat counter = 0, mode_err = 0.
REQ-031 During reset and on the first cycle after: out_valid = 0, sorted_data = 0, out_last = 1, beat_idx = 0, in_ready = 1.
REQ-032 Reset mid-word discards remaining beats; no partial beat emitted after reset release.
REQ-033 Reset has priority over a simultaneous accept or beat handshake.

Verification (DATA_W=32, LANE_W=2, MAX_MODE=2)
REQ-034 Mode 0, buffer 0xDEADBEEF, out_ready=1 -> one beat 0xDEADBEEF, out_last=1, beat_idx=0, in_ready=1 the same cycle.
REQ-035 Mode 1, buffer 0x1234A5C3 -> beat0 0xAA55F00F (last=0), beat1 0x050A0F50 (last=1).
REQ-036 Mode 2, buffer 0x000000E4 -> beats 0xFFAA5500, 0, 0, 0; out_last only on beat_idx=3.
REQ-037 Mode 1 word with out_ready=0 for 3 cycles on beat0 -> sorted_data stays 0xAA55F00F, in_ready=0 throughout; stream resumes correctly.
REQ-038 Continuous in_valid: mode 1 word 0x1234A5C3, then mode 0 word 0x0BADF00D presented with weight_bitwidth changed early -> beats 0xAA55F00F, 0x050A0F50, 0x0BADF00D on consecutive cycles with no bubble.
REQ-039 Mode 3 word 0xCAFEBABE -> single beat 0xCAFEBABE, mode_err=1 sticky; reset_n low mid-way through a mode 2 word -> out_valid=0, mode_err=0 next cycle, no stale beats.

Source files
------------

// File: rtl/input_lane_replicator.sv
`default_nettype none
// ============================================================================
//  Module   : input_lane_replicator
//  Purpose  : Takes one raw buffer word and emits it as 2^mode beats. Each
//             beat is one chunk of the word, with every LANE_W-bit lane of
//             the chunk repeated 2^mode times, so a reduced-precision operand
//             fills the full datapath width. Mode 0 passes the word through
//             unchanged as a single beat.
//  Ports    : clk, reset_n          - clock, synchronous active-low reset
//             weight_bitwidth       - mode select, captured with each word
//             in_valid / in_ready   - word handshake (upstream side)
//             buffer                - raw word
//             out_valid / out_ready - beat handshake (downstream side)
//             sorted_data           - replicated beat
//             out_last / beat_idx   - final-beat flag and beat index
//             mode_err              - sticky illegal-mode flag
//  Revision : 1.0 - initial release
// ============================================================================
module input_lane_replicator #(
    parameter int DATA_W   = 32,
    parameter int LANE_W   = 2,
    parameter int MAX_MODE = 2,
    localparam int BIDX_W  = (MAX_MODE < 1) ? 1 : MAX_MODE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        weight_bitwidth,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] buffer,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sorted_data,
    output logic              out_last,
    output logic [BIDX_W-1:0] beat_idx,
    output logic              mode_err
);

    // Every mode must split the word into whole lanes.
    if ((DATA_W % (LANE_W * (1 << MAX_MODE))) != 0) begin : g_param_check
        $error("input_lane_replicator: DATA_W must be divisible by LANE_W*2^MAX_MODE");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [1:0]          mode_q, mode_d;
    logic [BIDX_W-1:0]   cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                w_accept;
    logic                w_beat_hs;
    logic                w_mode_illegal;
    logic [BIDX_W-1:0]   w_last_cnt;
    logic [(MAX_MODE+1)*DATA_W-1:0] w_beats;

    // ------------------------------------------------------------------
    // Beat datapath: for each mode, build every candidate beat from fixed
    // slices of word_q and pick the one addressed by the beat counter.
    // Only registered state feeds this path.
    // ------------------------------------------------------------------
    for (genvar m = 0; m <= MAX_MODE; m++) begin : g_mode
        localparam int R       = 1 << m;
        localparam int CHUNK_W = DATA_W / R;
        localparam int NLANE   = CHUNK_W / LANE_W;

        logic [R*DATA_W-1:0] w_cand;
        logic [DATA_W-1:0]   w_beat;

        for (genvar b = 0; b < R; b++) begin : g_beat
            for (genvar i = 0; i < NLANE; i++) begin : g_lane
                assign w_cand[b*DATA_W + i*LANE_W*R +: LANE_W*R] =
                    {R{word_q[b*CHUNK_W + i*LANE_W +: LANE_W]}};
            end
        end

        always_comb begin
            w_beat = '0;
            for (int b = 0; b < R; b++) begin
                if (cnt_q == BIDX_W'(b)) begin
                    w_beat = w_cand[b*DATA_W +: DATA_W];
                end
            end
        end

        assign w_beats[m*DATA_W +: DATA_W] = w_beat;
    end

    always_comb begin
        sorted_data = '0;
        for (int m = 0; m <= MAX_MODE; m++) begin
            if (32'(mode_q) == m) begin
                sorted_data = w_beats[m*DATA_W +: DATA_W];
            end
        end
    end

    assign w_last_cnt = BIDX_W'((32'd1 << mode_q) - 32'd1);
    assign out_last   = (cnt_q == w_last_cnt);
    assign beat_idx   = cnt_q;
    assign mode_err   = err_q;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign w_mode_illegal = (32'(weight_bitwidth) > MAX_MODE);

    always_comb begin
        out_valid = (state_q == ST_BUSY);
        w_beat_hs = out_valid && out_ready;
        // A new word may enter on the same edge the final beat leaves,
        // which keeps back-to-back words bubble-free.
        in_ready  = (state_q == ST_IDLE) || (w_beat_hs && out_last);
        w_accept  = in_valid && in_ready;

        state_d = state_q;
        word_d  = word_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_beat_hs && out_last) begin
                    state_d = w_accept ? ST_BUSY : ST_IDLE;
                end else if (w_beat_hs) begin
                    cnt_d = cnt_q + BIDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_accept) begin
            word_d = buffer;
            cnt_d  = '0;
            if (w_mode_illegal) begin
                // Illegal modes fall back to pass-through so data still flows.
                mode_d = 2'd0;
                err_d  = 1'b1;
            end else begin
                mode_d = weight_bitwidth;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            mode_q  <= 2'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire
